act_func_stream: RTL

Multi-lane, multi-mode activation unit with a valid/ready streaming interface and a 2-stage pipeline.
- Modes: ReLU, leaky ReLU, hardtanh and piecewise-linear sigmoid, selectable per beat.
- Sits between the accumulator/requantiser output and the feature-map writeback buffer.
- Processes LANES signed fixed-point elements per accepted beat, with full backpressure support.

---
 rtl/act_func_stream.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/act_func_stream.sv
// Two-stage valid/ready activation unit: relu, leaky relu, hardtanh and piecewise sigmoid per lane.
// Define ACT_CLIP_CNT_EN to build the saturating hardtanh clip counter driven onto oClipCnt.
module act_func_stream #(
    parameter int WIDTH         = 8,
    parameter int LANES         = 4,
    parameter int DECIMAL_POINT = 5,
    parameter int LEAKY_SHIFT   = 5
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [1:0]               iMode,
    input  logic [LANES*WIDTH-1:0]   iData,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [LANES*WIDTH-1:0]   oData,
    output logic [1:0]               oMode,
    input  logic                     iClrCnt,
    output logic [15:0]              oClipCnt
);
    // ONE <= 2^(WIDTH-2), so every intermediate and result fits in WIDTH signed bits.
    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1 << DECIMAL_POINT);
    localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;
    localparam logic signed [WIDTH-1:0] HALF    = WIDTH'(1 << (DECIMAL_POINT - 1));
    localparam logic [WIDTH-2:0]        IP_MAX  = (WIDTH-1)'(WIDTH);
    localparam logic [WIDTH-2:0]        ABS_MAX = {(WIDTH-1){1'b1}};

    localparam logic [1:0] MODE_RELU  = 2'd0;
    localparam logic [1:0] MODE_LEAKY = 2'd1;
    localparam logic [1:0] MODE_HTANH = 2'd2;

    logic                       adv1;
    logic                       adv2;
    logic                       accept;
    logic                       v1;
    logic                       v2;
    logic [1:0]                 mode1;
    logic [1:0]                 mode2;
    logic [LANES*WIDTH-1:0]     x1;
    logic [LANES*WIDTH-1:0]     y2;
    logic [LANES*WIDTH-1:0]     y_next;
    logic [LANES*(WIDTH-1)-1:0] abs_in;
    logic [LANES*(WIDTH-1)-1:0] abs1;
    logic [LANES-1:0]           gt_in;
    logic [LANES-1:0]           lt_in;
    logic [LANES-1:0]           gt1;
    logic [LANES-1:0]           lt1;

    assign adv2   = !v2 || iReady;
    assign adv1   = !v1 || adv2;
    assign oReady = adv1;
    assign accept = iValid && adv1;
    assign oValid = v2;
    assign oData  = y2;
    assign oMode  = mode2;

    // Front end: magnitude with the most negative code saturated, plus hardtanh clip flags.
    for (genvar k = 0; k < LANES; k++) begin : g_front
        logic signed [WIDTH-1:0] x;
        logic [WIDTH-1:0]        mag;
        assign x   = iData[k*WIDTH +: WIDTH];
        assign mag = x[WIDTH-1] ? -x : x;
        assign abs_in[k*(WIDTH-1) +: WIDTH-1] = mag[WIDTH-1] ? ABS_MAX : mag[WIDTH-2:0];
        assign gt_in[k] = x > ONE;
        assign lt_in[k] = x < NEG_ONE;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_back
        logic signed [WIDTH-1:0]  x;
        logic signed [WIDTH-1:0]  num;
        logic signed [WIDTH-1:0]  t;
        logic signed [WIDTH-1:0]  sig;
        logic signed [WIDTH-1:0]  y;
        logic [WIDTH-2:0]         a;
        logic [WIDTH-2:0]         ip;
        logic [DECIMAL_POINT-1:0] fp;

        assign x   = x1[k*WIDTH +: WIDTH];
        assign a   = abs1[k*(WIDTH-1) +: WIDTH-1];
        assign ip  = a >> DECIMAL_POINT;
        assign fp  = a[DECIMAL_POINT-1:0];
        assign num = HALF - WIDTH'(fp >> 2);
        assign t   = (ip >= IP_MAX) ? '0 : num >> ip;
        assign sig = x[WIDTH-1] ? t : ONE - t;

        always_comb begin
            case (mode1)
                MODE_RELU:  y = x[WIDTH-1] ? '0 : x;
                MODE_LEAKY: y = x[WIDTH-1] ? (x >>> LEAKY_SHIFT) : x;
                MODE_HTANH: y = gt1[k] ? ONE : (lt1[k] ? NEG_ONE : x);
                default:    y = sig;
            endcase
        end

        assign y_next[k*WIDTH +: WIDTH] = y;
    end

    // Data registers load only on real transfers so idle cycles never disturb held outputs.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            mode1 <= '0;
            mode2 <= '0;
            x1    <= '0;
            abs1  <= '0;
            gt1   <= '0;
            lt1   <= '0;
            y2    <= '0;
        end else begin
            if (adv1) begin
                v1 <= iValid;
            end
            if (accept) begin
                mode1 <= iMode;
                x1    <= iData;
                abs1  <= abs_in;
                gt1   <= gt_in;
                lt1   <= lt_in;
            end
            if (adv2) begin
                v2 <= v1;
            end
            if (adv2 && v1) begin
                mode2 <= mode1;
                y2    <= y_next;
            end
        end
    end

`ifdef ACT_CLIP_CNT_EN
    logic [15:0] clip_cnt;
    logic [4:0]  clip_lanes;
    logic [16:0] clip_sum;

    always_comb begin
        clip_lanes = '0;
        for (int k = 0; k < LANES; k++) begin
            clip_lanes = clip_lanes + 5'(gt_in[k] | lt_in[k]);
        end
    end

    assign clip_sum = {1'b0, clip_cnt} + 17'(clip_lanes);

    // Clear wins over a same-cycle increment; the count sticks at all ones.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            clip_cnt <= '0;
        end else if (iClrCnt) begin
            clip_cnt <= '0;
        end else if (accept && iMode == MODE_HTANH) begin
            clip_cnt <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
        end
    end

    assign oClipCnt = clip_cnt;
`else
    logic unused_clr;
    assign unused_clr = iClrCnt;
    assign oClipCnt   = '0;
`endif

endmodule
